// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem request at a time and
// hands each fetched word to decode over a valid/ready handshake.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_snpc,
   output logic        out_fault,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HOLD, HALT} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_out_pc;
   logic        r_fault;
   logic [31:0] r_cnt;
   logic        w_fire;
   logic        w_hs;
   logic [31:0] w_redir_pc;

   assign w_fire     = (r_state == REQ) && imem_req_ready;
   assign w_hs       = (r_state == HOLD) && out_ready;
   assign w_redir_pc = redirect_pc & ~32'h3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= BOOT;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         BOOT:  w_next = REQ;
         REQ:   if (w_fire) w_next = redirect_valid ? DRAIN : WAIT;
         // A redirect racing the response discards it; otherwise it is still owed.
         WAIT: begin
            if (redirect_valid)      w_next = imem_rsp_valid ? REQ : DRAIN;
            else if (imem_rsp_valid) w_next = HOLD;
         end
         DRAIN: if (imem_rsp_valid) w_next = REQ;
         HOLD: begin
            if (w_hs)                w_next = (halt || r_fault) ? HALT : REQ;
            else if (redirect_valid) w_next = REQ;
         end
         HALT:    w_next = HALT;
         default: w_next = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_inst   <= '0;
         r_out_pc <= '0;
         r_fault  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            REQ, DRAIN: if (redirect_valid) r_pc <= w_redir_pc;
            WAIT: begin
               if (redirect_valid) begin
                  r_pc <= w_redir_pc;
               end else if (imem_rsp_valid) begin
                  r_inst   <= imem_rsp_data;
                  r_out_pc <= r_pc;
                  r_fault  <= imem_rsp_err;
               end
            end
            HOLD: begin
               if (w_hs) begin
                  r_pc  <= redirect_valid ? w_redir_pc : r_pc + 32'd4;
                  r_cnt <= r_cnt + 32'd1;
               end else if (redirect_valid) begin
                  r_pc <= w_redir_pc;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      imem_req_valid = (r_state == REQ);
      imem_req_addr  = (r_state == BOOT) ? '0 : r_pc;
      out_valid      = (r_state == HOLD);
      out_inst       = r_inst;
      out_pc         = r_out_pc;
      out_snpc       = (r_state == BOOT) ? '0 : r_out_pc + 32'd4;
      out_fault      = r_fault;
      halted         = (r_state == HALT);
      fetch_cnt      = r_cnt;
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a latency-randomised memory plus a PC-sequence model
// (next PC, handshake count, halted) that every scenario checks against.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid, imem_rsp_err;
   logic [31:0] imem_rsp_data;
   logic        out_valid, out_ready, out_fault;
   logic [31:0] out_inst, out_pc, out_snpc;
   logic        redirect_valid, halt, halted;
   logic [31:0] redirect_pc, fetch_cnt;

   ifu_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .imem_rsp_err(imem_rsp_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_snpc(out_snpc), .out_fault(out_fault),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .halted(halted), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // memory configuration
   logic        mem_const = 1'b1;
   logic        force_low = 1'b0;
   int unsigned ready_pct = 100;
   int unsigned lat_min = 1, lat_max = 1;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;
   logic        mem_pend = 1'b0, mem_overlap = 1'b0;
   logic [31:0] mem_addr = '0;
   int unsigned mem_delay = 0;

   // reference model
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_cnt = '0;
   logic        m_halted = 1'b0;

   // per-edge observations
   logic        s_rst, s_rv, s_rr, s_ov, s_or, s_ofault, s_redir, s_halt;
   logic [31:0] s_addr, s_opc, s_oinst, s_osnpc, s_rpc;
   logic        ev_fire, ev_hs, ev_fault;
   logic [31:0] ev_faddr, ev_fexp, ev_pc, ev_inst, ev_snpc, ev_exp_pc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (mem_const) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic errf(input logic [31:0] a);
      return err_en && (a == err_addr);
   endfunction

   task automatic tick();
      @(negedge clk);
      s_rst = rst; s_rv = imem_req_valid; s_rr = imem_req_ready; s_addr = imem_req_addr;
      s_ov = out_valid; s_or = out_ready; s_opc = out_pc; s_oinst = out_inst;
      s_osnpc = out_snpc; s_ofault = out_fault; s_redir = redirect_valid;
      s_rpc = redirect_pc; s_halt = halt;
      @(posedge clk);
      cyc++;
      ev_fire = s_rv && s_rr; ev_faddr = s_addr; ev_fexp = m_pc;
      ev_hs = s_ov && s_or; ev_pc = s_opc; ev_inst = s_oinst; ev_snpc = s_osnpc;
      ev_fault = s_ofault; ev_exp_pc = m_pc;
      if (s_rst) begin
         mem_pend = 1'b0; m_pc = RESET_PC; m_cnt = '0; m_halted = 1'b0;
      end else begin
         if (ev_fire) begin
            mem_overlap = mem_overlap | mem_pend;
            mem_pend = 1'b1; mem_addr = s_addr;
            mem_delay = $urandom_range(lat_max - 1, lat_min - 1);
         end
         if (!m_halted) begin
            if (ev_hs) begin
               m_cnt = m_cnt + 32'd1;
               if (s_halt || errf(m_pc)) m_halted = 1'b1;
               m_pc = s_redir ? (s_rpc & ~32'h3) : m_pc + 32'd4;
            end else if (s_redir) begin
               m_pc = s_rpc & ~32'h3;
            end
         end
      end
      #1;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
      if (rst) mem_pend = 1'b0;
      if (mem_pend) begin
         if (mem_delay == 0) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = memword(mem_addr);
            imem_rsp_err = errf(mem_addr); mem_pend = 1'b0;
         end else begin
            mem_delay--;
         end
      end
      imem_req_ready = force_low ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; halt = 1'b0; redirect_pc = '0;
      repeat (3) tick();
      n_vec++;
      if ({imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_snpc,
           out_fault, halted, fetch_cnt} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got req=%b addr=%h ov=%b inst=%h pc=%h snpc=%h f=%b h=%b cnt=%0d exp all zero",
                  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, out_snpc,
                  out_fault, halted, fetch_cnt);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
         n_err++;
         $display("FAIL reset_first_req got valid=%b addr=%h exp valid=1 addr=%h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
   endtask

   task automatic test_basic();
      int hs_n = 0, fire_cyc = -1, first_ov = -1, last_hs = 0;
      logic [31:0] exp_pc;
      mem_const = 1'b1; lat_min = 1; lat_max = 1; ready_pct = 100; out_ready = 1'b1;
      for (int i = 0; i < 40 && hs_n < 3; i++) begin
         tick();
         if (ev_fire && fire_cyc < 0) begin
            fire_cyc = cyc;
            n_vec++;
            if (ev_faddr !== RESET_PC) begin
               n_err++; $display("FAIL basic_first_addr got=%h exp=%h", ev_faddr, RESET_PC);
            end
         end
         if (ev_hs) begin
            exp_pc = RESET_PC + 32'(4 * hs_n);
            n_vec++;
            if ({ev_pc, ev_inst, ev_snpc, ev_fault} !== {exp_pc, 32'h13, exp_pc + 32'd4, 1'b0}) begin
               n_err++;
               $display("FAIL basic_out[%0d] got pc=%h inst=%h snpc=%h f=%b exp pc=%h inst=00000013 snpc=%h f=0",
                        hs_n, ev_pc, ev_inst, ev_snpc, ev_fault, exp_pc, exp_pc + 32'd4);
            end
            if (hs_n > 0) begin
               n_vec++;
               if (cyc - last_hs != 3) begin
                  n_err++; $display("FAIL basic_throughput got=%0d exp=3 cycles", cyc - last_hs);
               end
            end
            last_hs = cyc; hs_n++;
         end
         if (out_valid && first_ov < 0) first_ov = cyc;
      end
      n_vec++;
      if (hs_n != 3) begin n_err++; $display("FAIL basic_hs_count got=%0d exp=3", hs_n); end
      n_vec++;
      if (fetch_cnt !== 32'd3) begin n_err++; $display("FAIL basic_fetch_cnt got=%0d exp=3", fetch_cnt); end
      n_vec++;
      if (first_ov - fire_cyc != 1) begin
         n_err++; $display("FAIL basic_latency got=%0d exp=1 cycle after response edge", first_ov - fire_cyc);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if ({imem_req_valid, imem_req_addr, out_valid, ev_fire} !== {1'b1, RESET_PC, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL stall[%0d] got valid=%b addr=%h ov=%b fire=%b exp valid=1 addr=%h ov=0 fire=0",
                     i, imem_req_valid, imem_req_addr, out_valid, ev_fire, RESET_PC);
         end
      end
      force_low = 1'b0;
   endtask

   task automatic test_redirect_wait();
      logic found = 1'b0, saw_ov = 1'b0;
      mem_const = 1'b0; lat_min = 2; lat_max = 2; ready_pct = 100; out_ready = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin tick(); found = ev_fire; end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(); saw_ov = saw_ov | out_valid; found = ev_fire;
      end
      n_vec++;
      if ({found, saw_ov, ev_faddr} !== {1'b1, 1'b0, 32'h8000_0100}) begin
         n_err++;
         $display("FAIL redir_wait got found=%b stale_out=%b addr=%h exp found=1 stale_out=0 addr=80000100",
                  found, saw_ov, ev_faddr);
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin tick(); found = ev_hs; end
      n_vec++;
      if ({found, ev_pc, ev_inst} !== {1'b1, 32'h8000_0100, memword(32'h8000_0100)}) begin
         n_err++;
         $display("FAIL redir_wait_out got hs=%b pc=%h inst=%h exp hs=1 pc=80000100 inst=%h",
                  found, ev_pc, ev_inst, memword(32'h8000_0100));
      end
   endtask

   task automatic test_hold();
      logic found = 1'b0;
      logic [31:0] hi, hp, hc;
      lat_min = 1; lat_max = 3; ready_pct = 100; out_ready = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin tick(); found = out_valid; end
      hi = out_inst; hp = out_pc; hc = fetch_cnt;
      n_vec++;
      if ({found, hp, hi} !== {1'b1, m_pc, memword(m_pc)}) begin
         n_err++;
         $display("FAIL hold_entry got ov=%b pc=%h inst=%h exp ov=1 pc=%h inst=%h",
                  found, hp, hi, m_pc, memword(m_pc));
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if ({out_valid, out_inst, out_pc, fetch_cnt} !== {1'b1, hi, hp, hc}) begin
            n_err++;
            $display("FAIL hold_stable[%0d] got ov=%b inst=%h pc=%h cnt=%0d exp ov=1 inst=%h pc=%h cnt=%0d",
                     i, out_valid, out_inst, out_pc, fetch_cnt, hi, hp, hc);
         end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0043; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b0;
      n_vec++;
      if ({ev_hs, fetch_cnt} !== {1'b1, hc + 32'd1}) begin
         n_err++; $display("FAIL hold_handshake got hs=%b cnt=%0d exp hs=1 cnt=%0d", ev_hs, fetch_cnt, hc + 32'd1);
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin tick(); found = ev_fire; end
      n_vec++;
      if ({found, ev_faddr, fetch_cnt} !== {1'b1, 32'h8000_0040, hc + 32'd1}) begin
         n_err++;
         $display("FAIL hold_redirect got fire=%b addr=%h cnt=%0d exp fire=1 addr=80000040 cnt=%0d",
                  found, ev_faddr, fetch_cnt, hc + 32'd1);
      end
   endtask

   task automatic test_halt();
      logic found = 1'b0;
      logic [31:0] hc;
      out_ready = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin tick(); found = out_valid; end
      halt = 1'b1; out_ready = 1'b1;
      tick();
      halt = 1'b0;
      n_vec++;
      if ({found, ev_hs, halted} !== 3'b111) begin
         n_err++; $display("FAIL halt_enter got ov=%b hs=%b halted=%b exp 1 1 1", found, ev_hs, halted);
      end
      hc = fetch_cnt;
      for (int i = 0; i < 20; i++) begin
         redirect_valid = 1'b1; redirect_pc = $urandom; out_ready = 1'($urandom_range(1, 0));
         tick();
         n_vec++;
         if ({imem_req_valid, out_valid, halted, fetch_cnt, ev_fire} !== {1'b0, 1'b0, 1'b1, hc, 1'b0}) begin
            n_err++;
            $display("FAIL halt_hold[%0d] got req=%b ov=%b halted=%b cnt=%0d exp req=0 ov=0 halted=1 cnt=%0d",
                     i, imem_req_valid, out_valid, halted, fetch_cnt, hc);
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_fault();
      logic found = 1'b0;
      mem_const = 1'b1; lat_min = 1; lat_max = 1; ready_pct = 100; out_ready = 1'b1;
      err_en = 1'b1; err_addr = 32'h8000_0008;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (ev_hs) begin
            found = (ev_pc == 32'h8000_0008);
            n_vec++;
            if (ev_fault !== found) begin
               n_err++; $display("FAIL fault_flag pc=%h got=%b exp=%b", ev_pc, ev_fault, found);
            end
         end
      end
      n_vec++;
      if ({found, halted} !== 2'b11) begin
         n_err++; $display("FAIL fault_halt got seen=%b halted=%b exp 1 1", found, halted);
      end
      tick();
      n_vec++;
      if ({imem_req_valid, halted} !== 2'b01) begin
         n_err++; $display("FAIL fault_stop got req=%b halted=%b exp req=0 halted=1", imem_req_valid, halted);
      end
      err_en = 1'b0;
   endtask

   task automatic test_random();
      int n_hs = 0;
      mem_const = 1'b0; lat_min = 1; lat_max = 4; ready_pct = 60; mem_overlap = 1'b0;
      for (int i = 0; i < 600; i++) begin
         out_ready = ($urandom_range(9, 0) < 7);
         redirect_valid = ($urandom_range(99, 0) < 8);
         redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3, 0))) : $urandom;
         tick();
         if (ev_fire) begin
            n_vec++;
            if (ev_faddr !== ev_fexp) begin
               n_err++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, ev_faddr, ev_fexp);
            end
         end
         if (ev_hs) begin
            n_hs++;
            n_vec++;
            if ({ev_pc, ev_inst, ev_snpc, ev_fault} !==
                {ev_exp_pc, memword(ev_exp_pc), ev_exp_pc + 32'd4, 1'b0}) begin
               n_err++;
               $display("FAIL rand_out cyc=%0d got pc=%h inst=%h snpc=%h f=%b exp pc=%h inst=%h snpc=%h f=0",
                        cyc, ev_pc, ev_inst, ev_snpc, ev_fault, ev_exp_pc, memword(ev_exp_pc), ev_exp_pc + 32'd4);
            end
         end
         n_vec++;
         if (fetch_cnt !== m_cnt) begin
            n_err++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, fetch_cnt, m_cnt);
         end
      end
      redirect_valid = 1'b0;
      n_vec++;
      if (mem_overlap !== 1'b0 || n_hs < 20) begin
         n_err++; $display("FAIL rand_progress got overlap=%b handshakes=%0d exp overlap=0 handshakes>=20", mem_overlap, n_hs);
      end
   endtask

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      imem_rsp_err = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      test_reset();
      test_basic();
      force_low = 1'b1;
      test_reset();
      test_stall();
      test_redirect_wait();
      test_hold();
      test_halt();
      test_reset();
      test_fault();
      test_reset();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
